// File: rtl/fft_frame_buffer.sv
// Streaming front end for the FFT. It applies optional first-order pre-emphasis and collects
// overlapping N-sample frames into a double-buffered complex frame for the FFT stage.
module fft_frame_buffer #(
    parameter int N        = 256,
    parameter int HOP      = 128,
    parameter int SAMPLE_W = 12,
    parameter int W        = 23,
    parameter int BIT_FRAC = 8,
    parameter int PE_EN    = 1,
    parameter int PE_SHIFT = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [W:0]          frame_x [N][2],
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic                       overrun,
    output logic [15:0]                frame_count
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    if (W + 1 < SAMPLE_W + 2 + BIT_FRAC) begin : g_width_check
        $error("fft_frame_buffer: W+1 must be at least SAMPLE_W+2+BIT_FRAC");
    end
    if (HOP < 1 || HOP > N) begin : g_hop_check
        $error("fft_frame_buffer: HOP must lie in 1..N");
    end

    logic signed [W:0]          frame_buf [N];
    logic signed [W:0]          frame_re  [N];
    logic signed [W:0]          done_frame [N];
    logic [PW-1:0]              wr_ptr;
    logic signed [SAMPLE_W-1:0] s_prev;

    logic signed [SAMPLE_W+1:0] s_ext;
    logic signed [SAMPLE_W+1:0] p_ext;
    logic signed [SAMPLE_W+1:0] e;
    logic signed [W:0]          e_wide;
    logic signed [W:0]          stored;
    logic                       complete;
    logic                       release_ok;
    logic                       consume;

    // The two spare bits keep s - s_prev + (s_prev >>> PE_SHIFT) free of overflow.
    assign s_ext  = {{2{sample[SAMPLE_W-1]}}, sample};
    assign p_ext  = {{2{s_prev[SAMPLE_W-1]}}, s_prev};
    assign e      = (PE_EN != 0) ? (s_ext - p_ext + (p_ext >>> PE_SHIFT)) : s_ext;
    assign e_wide = {{(W - SAMPLE_W - 1){e[SAMPLE_W+1]}}, e};
    assign stored = e_wide <<< BIT_FRAC;

    // FILL and STEADY differ only in where wr_ptr restarts, so wr_ptr carries the whole state.
    assign complete   = sample_valid && (wr_ptr == PW'(N - 1));
    assign consume    = frame_valid && frame_ready;
    assign release_ok = !frame_valid || frame_ready;

    always_comb begin
        for (int k = 0; k < N - 1; k++) begin
            done_frame[k] = frame_buf[k];
        end
        done_frame[N-1] = stored;
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            frame_x[k][0] = frame_re[k];
            frame_x[k][1] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                frame_buf[k] <= '0;
                frame_re[k]  <= '0;
            end
            wr_ptr      <= '0;
            s_prev      <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (sample_valid) begin
                s_prev <= sample;
            end

            if (complete) begin
                if (release_ok) begin
                    for (int k = 0; k < N; k++) begin
                        frame_re[k] <= done_frame[k];
                    end
                    frame_valid <= 1'b1;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    overrun <= 1'b1;
                end
                // The overlap includes the completing sample, so shift from the finished frame.
                for (int k = 0; k < N - HOP; k++) begin
                    frame_buf[k] <= done_frame[k + HOP];
                end
                wr_ptr <= PW'(N - HOP);
            end else begin
                if (sample_valid) begin
                    frame_buf[wr_ptr] <= stored;
                    wr_ptr            <= wr_ptr + 1'b1;
                end
                if (consume) begin
                    frame_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

- Upstream front-end stage of the FFT: accepts the streaming audio sample flow, applies optional first-order pre-emphasis, and assembles overlapping N-sample frames.
- Each complete frame is presented as a parallel complex fixed-point array, imaginary parts zero, in the exact shape the FFT input expects.
- Output frame is double-buffered, so sample capture never stalls while the FFT consumes the previous frame.

## Interface
- N, 256: frame length (power of two, matches FFT N)
- HOP, 128: new samples per frame after the first (N/2 gives 50 % overlap; 1 ≤ HOP ≤ N)
- SAMPLE_W, 12: signed input sample width
- W, 23: FFT data MSB index; each frame element is W+1 bits signed
- BIT_FRAC, 8: fractional bits of the FFT fixed-point format
- PE_EN, 1: 1 = pre-emphasis on, 0 = bypass
- PE_SHIFT, 5: pre-emphasis coefficient alpha = 1 − 2^-PE_SHIFT
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- sample_valid  in  1  sample strobe; one sample accepted per cycle when high
- sample  in  SAMPLE_W  signed PCM sample
- frame_x  out  [N][2][W+1]  signed frame; [k][0] real, [k][1] imaginary (always 0)
- frame_valid  out  1  frame_x holds an unconsumed frame
- frame_ready  in  1  FFT consumer takes the frame on a cycle where frame_valid && frame_ready
- overrun  out  1  sticky; a completed frame was dropped
- frame_count  out  16  frames delivered to frame_x, wraps at 2^16

## Operation
- Working buffer buf[0..N-1] (W+1 bits each) and write pointer wr_ptr (0..N-1). A sample register s_prev is also kept.
- Accepted sample s gives e = s − s_prev + (s_prev >>> PE_SHIFT). e is computed at SAMPLE_W+2 bits signed; >>> is arithmetic (floor). With PE_EN=0, e = s.
- s_prev ← s on every accepted sample.
- Stored value = sign-extend(e) <<< BIT_FRAC into W+1 bits. W+1 ≥ SAMPLE_W+2+BIT_FRAC is required (elaboration assertion), so no saturation is needed.
- States:
  - FILL (after reset): write buf[wr_ptr], wr_ptr++. Writing index N-1 completes the frame.
  - STEADY: same write path; frame completes when wr_ptr = N-1 is written.
- On frame completion:
  - Release check: release is allowed if frame_valid=0, or frame_valid=1 && frame_ready=1 on the same edge.
  - If allowed: frame_x[k][0] ← buf[k] for k<N-1, with the element at N-1 taken from the incoming sample; frame_x[k][1] ← 0. frame_valid ← 1; frame_count++.
  - Otherwise: frame dropped, frame_x unchanged, overrun ← 1.
  - In both cases: buf[k] ← buf[k+HOP] for k < N−HOP; wr_ptr ← N−HOP; state ← STEADY.
- Consume without completion (frame_valid && frame_ready): frame_valid ← 0.
- s_prev is continuous across frames; pre-emphasis is not restarted per frame.

## Timing
- Reset values: frame_x all 0, frame_valid 0, overrun 0, frame_count 0. Internally wr_ptr 0, s_prev 0, buf all 0, state FILL.
- Reset mid-frame discards all partial data. The first frame after reset needs N fresh samples.
- Latency: frame_x/frame_valid update on the same clock edge that accepts the completing sample, i.e. visible one cycle after that sample is presented.
- Frame spacing: first frame after N samples, then every HOP samples.
- sample_valid may toggle arbitrarily; idle cycles change nothing.
- frame_x is stable whenever frame_valid=1 and no release occurs.
- overrun clears only on reset.

## Test plan
- Ramp, PE_EN=0: samples 0..255 back-to-back → frame_valid=1 after 256th, frame_x[k][0]=k·256, frame_x[k][1]=0, frame_count=1.
- Overlap: pulse frame_ready, then feed samples 256..383 → second frame holds 128..383 (frame_x[0][0]=128·256, frame_x[255][0]=383·256), frame_count=2, overrun=0.
- Overrun: frame_ready held 0 after frame 1, feed 128 more samples → overrun=1, frame_x still frame 1, frame_count=1. Then frame_ready=1 for one cycle → frame_valid=0.
- Simultaneous: frame_ready=1 on the same edge as frame completion with frame_valid=1 → new frame loaded, frame_valid stays 1, overrun=0.
- Pre-emphasis, PE_EN=1: constant input 32 → frame_x[0][0]=32·256=8192, frame_x[k][0]=256 for k≥1. Constant input −1 → first element −256, the rest −256 (−1+1+(−1>>>5)=−1).
- Reset mid-fill: 100 samples, assert rst for 2 cycles, then 256 samples of value 5 (PE_EN=0) → all frame_x[k][0]=1280, frame_count=1.
